// File: rtl/pit_rw_controller_if.sv
// CPU-side bus of the 8254 read/write controller: chip select, strobes, address and data.
// The CPU (or testbench) drives the master modport; the controller uses the slave modport.
interface pit_rw_controller_if;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic [1:0] a;
    logic [7:0] d_in;
    logic [7:0] d_out;
    logic       d_oe;

    modport master (
        output cs_n, rd_n, wr_n, a, d_in,
        input  d_out, d_oe
    );

    modport slave (
        input  cs_n, rd_n, wr_n, a, d_in,
        output d_out, d_oe
    );
endinterface

// File: rtl/pit_rw_controller.sv
// 8254 bus-side sequencer: decodes control/count writes, runs latch commands, muxes read bytes.
// Define PIT_READBACK_EN to enable the SC=11 read-back command; by default SC=11 writes are ignored.
module pit_rw_controller #(
    parameter int NUM_CNT = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    pit_rw_controller_if.slave      bus,
    input  logic [16*NUM_CNT-1:0]   count_in,
    input  logic [8*NUM_CNT-1:0]    status_in,
    output logic [7:0]              cw_out,
    output logic [NUM_CNT-1:0]      cw_load,
    output logic [7:0]              wr_byte,
    output logic [NUM_CNT-1:0]      crl_we,
    output logic [NUM_CNT-1:0]      crm_we,
    output logic                    crm_clr,
    output logic [NUM_CNT-1:0]      cr_done
);

    // Registered bus sample
    logic       cs_n_q, rd_n_q, wr_n_q;
    logic [1:0] a_q;
    logic [7:0] d_in_q;

    // Per-counter access state
    logic [1:0]         rw_mode_q [NUM_CNT];
    logic [1:0]         rw_mode_d [NUM_CNT];
    logic [NUM_CNT-1:0] wptr_q, wptr_d;
    logic [NUM_CNT-1:0] rptr_q, rptr_d;
    logic [NUM_CNT-1:0] cnt_latched_q, cnt_latched_d;
    logic [NUM_CNT-1:0] stat_latched_q, stat_latched_d;
    logic [15:0]        cnt_lat_q [NUM_CNT];
    logic [15:0]        cnt_lat_d [NUM_CNT];
    logic [7:0]         stat_lat_q [NUM_CNT];
    logic [7:0]         stat_lat_d [NUM_CNT];

    // Registered outputs
    logic [7:0]         cw_out_q, cw_out_d;
    logic [NUM_CNT-1:0] cw_load_q, cw_load_d;
    logic [7:0]         wr_byte_q, wr_byte_d;
    logic [NUM_CNT-1:0] crl_we_q, crl_we_d;
    logic [NUM_CNT-1:0] crm_we_q, crm_we_d;
    logic               crm_clr_q, crm_clr_d;
    logic [NUM_CNT-1:0] cr_done_q, cr_done_d;

    logic       wr_ev, rd_ev;
    logic [1:0] sc, rw;
    logic [15:0] rd_word;
    logic [7:0]  rd_byte;
    logic        rd_active;

    // Strobe rising edges: low in the registered sample, high on the live pin.
    assign wr_ev = ~cs_n_q & ~wr_n_q & bus.wr_n;
    assign rd_ev = ~cs_n_q & ~rd_n_q & bus.rd_n & (a_q != 2'd3) & ~wr_ev;
    assign sc    = d_in_q[7:6];
    assign rw    = d_in_q[5:4];

    always_comb begin
        rw_mode_d      = rw_mode_q;
        wptr_d         = wptr_q;
        rptr_d         = rptr_q;
        cnt_latched_d  = cnt_latched_q;
        stat_latched_d = stat_latched_q;
        cnt_lat_d      = cnt_lat_q;
        stat_lat_d     = stat_lat_q;
        cw_out_d       = cw_out_q;
        wr_byte_d      = wr_byte_q;
        cw_load_d      = '0;
        crl_we_d       = '0;
        crm_we_d       = '0;
        crm_clr_d      = 1'b0;
        cr_done_d      = '0;

        if (wr_ev) begin
            if (a_q == 2'd3) begin
                if (sc != 2'b11) begin
                    for (int n = 0; n < NUM_CNT; n++) begin
                        if (sc == 2'(n)) begin
                            if (rw == 2'b00) begin
                                if (!cnt_latched_q[n]) begin
                                    cnt_lat_d[n]     = count_in[16*n +: 16];
                                    cnt_latched_d[n] = 1'b1;
                                end
                            end else begin
                                cw_load_d[n]      = 1'b1;
                                cw_out_d          = d_in_q;
                                rw_mode_d[n]      = rw;
                                wptr_d[n]         = 1'b0;
                                rptr_d[n]         = 1'b0;
                                cnt_latched_d[n]  = 1'b0;
                                stat_latched_d[n] = 1'b0;
                            end
                        end
                    end
                end else begin
                    // Read-back. The status byte register may load in either build, but it
                    // only becomes visible once status_latched is set, which needs the macro.
                    for (int n = 0; n < NUM_CNT; n++) begin
                        if (d_in_q[n+1]) begin
`ifdef PIT_READBACK_EN
                            if (!d_in_q[5] && !cnt_latched_q[n]) begin
                                cnt_lat_d[n]     = count_in[16*n +: 16];
                                cnt_latched_d[n] = 1'b1;
                            end
`endif
                            if (!d_in_q[4] && !stat_latched_q[n]) begin
                                stat_lat_d[n] = status_in[8*n +: 8];
`ifdef PIT_READBACK_EN
                                stat_latched_d[n] = 1'b1;
`endif
                            end
                        end
                    end
                end
            end else begin
                for (int n = 0; n < NUM_CNT; n++) begin
                    if (a_q == 2'(n)) begin
                        wr_byte_d = d_in_q;
                        case (rw_mode_q[n])
                            2'b01: begin
                                crl_we_d[n]  = 1'b1;
                                crm_we_d[n]  = 1'b1;
                                crm_clr_d    = 1'b1;
                                cr_done_d[n] = 1'b1;
                            end
                            2'b10: begin
                                crm_we_d[n]  = 1'b1;
                                cr_done_d[n] = 1'b1;
                            end
                            2'b11: begin
                                if (!wptr_q[n]) begin
                                    crl_we_d[n] = 1'b1;
                                    wptr_d[n]   = 1'b1;
                                end else begin
                                    crm_we_d[n]  = 1'b1;
                                    cr_done_d[n] = 1'b1;
                                    wptr_d[n]    = 1'b0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end else if (rd_ev) begin
            for (int n = 0; n < NUM_CNT; n++) begin
                if (a_q == 2'(n)) begin
                    if (stat_latched_q[n]) begin
                        stat_latched_d[n] = 1'b0;
                    end else if (rw_mode_q[n] == 2'b11 && !rptr_q[n]) begin
                        rptr_d[n] = 1'b1;
                    end else begin
                        rptr_d[n]        = 1'b0;
                        cnt_latched_d[n] = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_n_q         <= 1'b1;
            rd_n_q         <= 1'b1;
            wr_n_q         <= 1'b1;
            a_q            <= 2'd0;
            d_in_q         <= 8'h00;
            wptr_q         <= '0;
            rptr_q         <= '0;
            cnt_latched_q  <= '0;
            stat_latched_q <= '0;
            for (int n = 0; n < NUM_CNT; n++) begin
                rw_mode_q[n]  <= 2'b01;
                cnt_lat_q[n]  <= 16'h0000;
                stat_lat_q[n] <= 8'h00;
            end
            cw_out_q  <= 8'h00;
            cw_load_q <= '0;
            wr_byte_q <= 8'h00;
            crl_we_q  <= '0;
            crm_we_q  <= '0;
            crm_clr_q <= 1'b0;
            cr_done_q <= '0;
        end else begin
            cs_n_q         <= bus.cs_n;
            rd_n_q         <= bus.rd_n;
            wr_n_q         <= bus.wr_n;
            a_q            <= bus.a;
            d_in_q         <= bus.d_in;
            rw_mode_q      <= rw_mode_d;
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
            cnt_latched_q  <= cnt_latched_d;
            stat_latched_q <= stat_latched_d;
            cnt_lat_q      <= cnt_lat_d;
            stat_lat_q     <= stat_lat_d;
            cw_out_q       <= cw_out_d;
            cw_load_q      <= cw_load_d;
            wr_byte_q      <= wr_byte_d;
            crl_we_q       <= crl_we_d;
            crm_we_q       <= crm_we_d;
            crm_clr_q      <= crm_clr_d;
            cr_done_q      <= cr_done_d;
        end
    end

    // Read byte: status latch first, then latched count, then the live count.
    always_comb begin
        rd_word = 16'h0000;
        rd_byte = 8'h00;
        for (int n = 0; n < NUM_CNT; n++) begin
            if (a_q == 2'(n)) begin
                rd_word = cnt_latched_q[n] ? cnt_lat_q[n] : count_in[16*n +: 16];
                if (stat_latched_q[n]) begin
                    rd_byte = stat_lat_q[n];
                end else begin
                    case (rw_mode_q[n])
                        2'b10:   rd_byte = rd_word[15:8];
                        2'b11:   rd_byte = rptr_q[n] ? rd_word[15:8] : rd_word[7:0];
                        default: rd_byte = rd_word[7:0];
                    endcase
                end
            end
        end
    end

    assign rd_active = ~cs_n_q & ~rd_n_q & (a_q != 2'd3);
    assign bus.d_oe  = rd_active;
    assign bus.d_out = rd_active ? rd_byte : 8'h00;

    assign cw_out  = cw_out_q;
    assign cw_load = cw_load_q;
    assign wr_byte = wr_byte_q;
    assign crl_we  = crl_we_q;
    assign crm_we  = crm_we_q;
    assign crm_clr = crm_clr_q;
    assign cr_done = cr_done_q;

endmodule

// File: tb/tb_pit_rw_controller.sv
// Scoreboard bench for pit_rw_controller: expected write pulses and read bytes are queued
// as bus cycles are issued and compared when the DUT raises pulses or d_oe.
module tb_pit_rw_controller;

    typedef struct {
        logic [2:0] cwLoad;
        logic [7:0] cwOut;
        logic [2:0] crlWe;
        logic [2:0] crmWe;
        logic       crmClr;
        logic [2:0] crDone;
        logic [7:0] wrByte;
    } wrRec_t;

    logic        clk;
    logic        rst;
    logic [47:0] countIn;
    logic [23:0] statusIn;
    logic [7:0]  cwOut;
    logic [2:0]  cwLoad;
    logic [7:0]  wrByte;
    logic [2:0]  crlWe;
    logic [2:0]  crmWe;
    logic        crmClr;
    logic [2:0]  crDone;

    int          testsRun;
    int          testsFailed;
    wrRec_t      wrQ[$];
    logic [7:0]  rdQ[$];
    wrRec_t      monRec;
    logic [7:0]  monByte;
    logic        prevOe;

    pit_rw_controller_if bus ();

    pit_rw_controller #(.NUM_CNT(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .count_in  (countIn),
        .status_in (statusIn),
        .cw_out    (cwOut),
        .cw_load   (cwLoad),
        .wr_byte   (wrByte),
        .crl_we    (crlWe),
        .crm_we    (crmWe),
        .crm_clr   (crmClr),
        .cr_done   (crDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic expectMode(input logic [2:0] onehot, input logic [7:0] cw);
        wrRec_t r;
        r.cwLoad = onehot; r.cwOut = cw; r.crlWe = 3'b000; r.crmWe = 3'b000;
        r.crmClr = 1'b0; r.crDone = 3'b000; r.wrByte = 8'h00;
        wrQ.push_back(r);
    endtask

    task automatic expectCount(input logic [2:0] crl, input logic [2:0] crm, input logic clr,
                               input logic [2:0] done, input logic [7:0] b);
        wrRec_t r;
        r.cwLoad = 3'b000; r.cwOut = 8'h00; r.crlWe = crl; r.crmWe = crm;
        r.crmClr = clr; r.crDone = done; r.wrByte = b;
        wrQ.push_back(r);
    endtask

    task automatic applyStimulus(input logic isWrite, input logic [1:0] addr, input logic [7:0] data);
        @(posedge clk); #1;
        bus.cs_n = 1'b0;
        bus.a    = addr;
        bus.d_in = data;
        if (isWrite) bus.wr_n = 1'b0; else bus.rd_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.wr_n = 1'b1;
        bus.rd_n = 1'b1;
        @(posedge clk); #1;
        bus.cs_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic busWrite(input logic [1:0] addr, input logic [7:0] data);
        applyStimulus(1'b1, addr, data);
    endtask

    task automatic busRead(input logic [1:0] addr, input logic [7:0] expByte);
        rdQ.push_back(expByte);
        applyStimulus(1'b0, addr, 8'h00);
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("resetOutputs",
                    {24'h0, cwOut, wrByte, cwLoad, crlWe, crmWe, crDone, crmClr, bus.d_oe, bus.d_out},
                    64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Pops the scoreboard whenever the DUT emits a write pulse or starts driving read data.
    always @(negedge clk) begin
        if (rst) begin
            prevOe = 1'b0;
        end else begin
            if (|{cwLoad, crlWe, crmWe, crDone}) begin
                if (wrQ.size() == 0) begin
                    checkOutput("unexpectedWrPulse", {52'h0, cwLoad, crlWe, crmWe, crDone}, 64'h0);
                end else begin
                    monRec = wrQ.pop_front();
                    checkOutput("cwLoad", cwLoad, monRec.cwLoad);
                    checkOutput("crlWe", crlWe, monRec.crlWe);
                    checkOutput("crmWe", crmWe, monRec.crmWe);
                    checkOutput("crmClr", crmClr, monRec.crmClr);
                    checkOutput("crDone", crDone, monRec.crDone);
                    if (monRec.cwLoad != 3'b000) checkOutput("cwOut", cwOut, monRec.cwOut);
                    else                         checkOutput("wrByte", wrByte, monRec.wrByte);
                end
            end
            if (bus.d_oe && !prevOe) begin
                if (rdQ.size() == 0) begin
                    checkOutput("unexpectedRead", {56'h0, bus.d_out}, 64'h0);
                end else begin
                    monByte = rdQ.pop_front();
                    checkOutput("readByte", bus.d_out, monByte);
                end
            end
            prevOe = bus.d_oe;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        prevOe      = 1'b0;
        rst         = 1'b1;
        bus.cs_n    = 1'b1;
        bus.rd_n    = 1'b1;
        bus.wr_n    = 1'b1;
        bus.a       = 2'd0;
        bus.d_in    = 8'h00;
        countIn     = 48'h0;
        statusIn    = 24'h0;
        repeat (3) @(posedge clk);
        doReset();

        // Counter 0 in LSB/MSB mode, then two count bytes
        expectMode(3'b001, 8'h34);                  busWrite(2'd3, 8'h34);
        expectCount(3'b001, 3'b000, 1'b0, 3'b000, 8'h10); busWrite(2'd0, 8'h10);
        expectCount(3'b000, 3'b001, 1'b0, 3'b001, 8'h27); busWrite(2'd0, 8'h27);

        // Counter 1 LSB-only: every strobe completes the count with MSB cleared
        expectMode(3'b010, 8'h50);                  busWrite(2'd3, 8'h50);
        expectCount(3'b010, 3'b010, 1'b1, 3'b010, 8'hAB); busWrite(2'd1, 8'hAB);

        // Counter 2 MSB-only
        expectMode(3'b100, 8'hA0);                  busWrite(2'd3, 8'hA0);
        expectCount(3'b000, 3'b100, 1'b0, 3'b100, 8'h5A); busWrite(2'd2, 8'h5A);

        // Counter latch, then live reads after release
        countIn[15:0] = 16'h1234;
        busWrite(2'd3, 8'h00);
        countIn[15:0] = 16'h2211;
        busRead(2'd0, 8'h34);
        busRead(2'd0, 8'h12);
        busRead(2'd0, 8'h11);
        busRead(2'd0, 8'h22);

        // Second latch command while latched is ignored
        countIn[15:0] = 16'h1234;
        busWrite(2'd3, 8'h00);
        countIn[15:0] = 16'h5555;
        busWrite(2'd3, 8'h00);
        busRead(2'd0, 8'h34);
        busRead(2'd0, 8'h12);

        // Mode word discards a pending latch
        countIn[15:0] = 16'h1234;
        busWrite(2'd3, 8'h00);
        expectMode(3'b001, 8'h34);                  busWrite(2'd3, 8'h34);
        countIn[15:0] = 16'h4321;
        busRead(2'd0, 8'h21);
        busRead(2'd0, 8'h43);

        // Live reads in single-byte modes; control address never drives
        countIn[31:16] = 16'hBEEF;
        countIn[47:32] = 16'hCAFE;
        busRead(2'd1, 8'hEF);
        busRead(2'd1, 8'hEF);
        busRead(2'd2, 8'hCA);
        applyStimulus(1'b0, 2'd3, 8'h00);

        // Read-back of counter 2 count and status
        expectMode(3'b100, 8'hB6);                  busWrite(2'd3, 8'hB6);
        statusIn[23:16] = 8'hB6;
        countIn[47:32]  = 16'h0F0E;
        busWrite(2'd3, 8'hC8);
        countIn[47:32]  = 16'h7766;
`ifdef PIT_READBACK_EN
        busRead(2'd2, 8'hB6);
        busRead(2'd2, 8'h0E);
        busRead(2'd2, 8'h0F);
`else
        busRead(2'd2, 8'h66);
        busRead(2'd2, 8'h77);
        busRead(2'd2, 8'h66);
`endif

        // Reset between LSB and MSB writes returns counter 1 to LSB-only mode
        expectMode(3'b010, 8'h70);                  busWrite(2'd3, 8'h70);
        expectCount(3'b010, 3'b000, 1'b0, 3'b000, 8'h11); busWrite(2'd1, 8'h11);
        doReset();
        expectCount(3'b010, 3'b010, 1'b1, 3'b010, 8'h22); busWrite(2'd1, 8'h22);

        // Strobe released during reset must not produce a write
        @(posedge clk); #1;
        bus.cs_n = 1'b0; bus.wr_n = 1'b0; bus.a = 2'd1; bus.d_in = 8'h99;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        bus.wr_n = 1'b1; bus.cs_n = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);

        repeat (3) @(posedge clk);
        checkOutput("wrQueueEmpty", wrQ.size(), 0);
        checkOutput("rdQueueEmpty", rdQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
